nco_sweep_ctrl: RTL

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

---
 rtl/nco_sweep_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep controller: steps an NCO phase increment from start to stop,
// holding each frequency for a programmable dwell, with optional looping.
module nco_sweep_ctrl #(
    parameter int unsigned PHASE_INC_BITS = 26,
    parameter int unsigned DWELL_BITS     = 16
) (
    input  logic                      CLK,
    input  logic                      RSTb,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [PHASE_INC_BITS-1:0] cfg_start,
    input  logic [PHASE_INC_BITS-1:0] cfg_stop,
    input  logic [PHASE_INC_BITS-1:0] cfg_step,
    input  logic [DWELL_BITS-1:0]     cfg_dwell,
    input  logic                      cfg_loop,
    input  logic                      abort,
    output logic [PHASE_INC_BITS-1:0] phase_inc,
    output logic                      busy,
    output logic                      step_strobe,
    output logic                      sweep_done
);

    localparam int unsigned PW = PHASE_INC_BITS;
    localparam int unsigned DW = DWELL_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   phase_nxt;
    logic [DW-1:0]   dwell_cnt, dwell_nxt;
    logic            strobe_nxt, done_nxt;
    logic            cfg_load;

    logic [PW-1:0]   start_q, stop_q, step_q;
    logic [DW-1:0]   dwell_q;
    logic            loop_q;

    // Next phase increment carries one extra bit so accumulator overflow ends the sweep
    logic [PW:0]     next_sum;
    logic            end_reached;

    assign next_sum    = {1'b0, phase_inc} + {1'b0, step_q};
    assign end_reached = (step_q == '0) || next_sum[PW] || (next_sum > {1'b0, stop_q});

    // Combinational ready: only in IDLE and never while abort is asserted
    assign cfg_ready = (state == IDLE) && !abort;
    assign busy      = (state != IDLE);

    // Next-state and datapath decode; abort overrides everything
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase_inc;
        dwell_nxt  = dwell_cnt;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        cfg_load   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            phase_nxt = '0;
            dwell_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        cfg_load  = 1'b1;
                        phase_nxt = cfg_start;
                        dwell_nxt = cfg_dwell;
                        state_nxt = DWELL;
                    end
                end
                DWELL: begin
                    if (dwell_cnt == '0) begin
                        state_nxt = STEP;
                    end else begin
                        dwell_nxt = dwell_cnt - DW'(1);
                    end
                end
                STEP: begin
                    if (!end_reached) begin
                        phase_nxt  = next_sum[PW-1:0];
                        strobe_nxt = 1'b1;
                        dwell_nxt  = dwell_q;
                        state_nxt  = DWELL;
                    end else if (loop_q) begin
                        phase_nxt = start_q;
                        dwell_nxt = dwell_q;
                        state_nxt = DWELL;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, datapath and pulse registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state       <= IDLE;
            phase_inc   <= '0;
            dwell_cnt   <= '0;
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            loop_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase_inc   <= phase_nxt;
            dwell_cnt   <= dwell_nxt;
            step_strobe <= strobe_nxt;
            sweep_done  <= done_nxt;
            if (cfg_load) begin
                start_q <= cfg_start;
                stop_q  <= cfg_stop;
                step_q  <= cfg_step;
                dwell_q <= cfg_dwell;
                loop_q  <= cfg_loop;
            end
        end
    end

endmodule
